booth_mul_seq: RTL
==================

// Module: booth_mul_seq
// PURPOSE
// - Sequential signed 32x32 -> 64-bit multiplier (radix-4 Booth), upstream of the HI/LO registers.
// - Each iteration adds one Booth partial product into a 64-bit accumulator through one
//   adder_64b instance.
// - Subtraction uses the same instance: x = acc, y = ~pp, cin = 1.
// - Result is presented as hi/lo with a start/busy/done handshake for the control unit.
// PARAMETERS
// - WIDTH  32  Operand width; must be even. Datapath is 2*WIDTH bits (64 -> adder_64b).
// - ITERS  WIDTH/2 (16)  Booth iterations; localparam, not overridable.
// PORTS
// - clk     in   1   Single clock; all state updates on the rising edge.
// - clr     in   1   Synchronous, active-high reset.
// - start   in   1   Request; sampled only in IDLE.
// - mcand   in   32  Multiplicand, two's complement; latched on the accepted start.
// - mplier  in   32  Multiplier, two's complement; latched on the accepted start.
// - busy    out  1   High in RUN.
// - done    out  1   One-cycle pulse: hi/lo are valid.
// - hi      out  32  Product[63:32].
// - lo      out  32  Product[31:0].
// BEHAVIOUR
// - Reset: when clr is high at an edge:
//   - state = IDLE; busy = 0; done = 0; hi = lo = 0; acc, counter and operand regs cleared.
//   - clr has priority over everything, including mid-RUN: the operation is aborted, no done.
// - States: IDLE -> RUN -> DONE -> IDLE.
// - IDLE:
//   - start = 1 at edge k: latch M = sext64(mcand) and Q = {mplier, 1'b0}; acc = 0; cnt = 0;
//     go to RUN.
//   - start = 0: hold. hi/lo keep the last result.
// - RUN, each edge (k+1 .. k+16):
//   - Decode Q[2:0]: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M.
//   - acc <= adder_64b(acc, pp, cin); Q <= Q >>> 2 (arithmetic); M <= M << 2; cnt <= cnt + 1.
//   - adder_64b cout is ignored: arithmetic is modulo 2^64.
//   - On the edge where cnt == ITERS-1 (edge k+16): {hi, lo} <= final acc sum; go to DONE.
// - DONE:
//   - done = 1 for exactly this cycle (after edge k+16); busy = 0.
//   - Next edge -> IDLE unconditionally; done falls.
// - Latency: start sampled at edge k -> done high during the cycle after edge k+16 (16 RUN cycles).
// - start while busy or done is ignored; it is not queued.
// - Operand input changes after the accepted edge have no effect.
// - hi/lo change only on the completing edge or on clr; they hold until the next completion.
// - Back-to-back operation: earliest next accepted start is the edge after DONE (IDLE).
//   Throughput is 1 product / 18 cycles.
// - Corner case: -2^31 * -2^31 = +2^62 is exact; no overflow flag exists or is needed.
// TESTING
// 1. mcand=3, mplier=5, start for one cycle -> done pulse 17 edges after start edge;
//    hi=0x00000000, lo=0x0000000F; busy high for exactly 16 cycles.
// 2. mcand=-7 (0xFFFFFFF9), mplier=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
//    also -1*-1 -> hi=0, lo=1.
// 3. 0x80000000*0x80000000 -> hi=0x40000000, lo=0;
//    0x7FFFFFFF*0x80000000 -> hi=0xC0000000, lo=0x80000000.
// 4. Start 2*3 (result 6); at RUN cycle 8: pulse start with new operands and change mcand/mplier
//    -> ignored, result still lo=6, hi=0.
// 5. Start 2*3; assert clr at RUN cycle 5 -> next cycle busy=0, done=0, hi=lo=0, no done pulse;
//    a following start of 4*4 -> lo=0x10.
// 6. 10k random signed pairs, back-to-back starts -> {hi,lo} == $signed(a)*$signed(b) every time;
//    done is always a single-cycle pulse.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTH x WIDTH multiplier, radix-4 Booth.
// One partial product per cycle accumulated through a single adder_64b.
module adder_64b #(
    parameter int N = 64
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
endmodule

module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int ITERS = WIDTH / 2;
    localparam int DW    = 2 * WIDTH;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   m;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   y;
    logic [DW-1:0]   sum;
    logic [WIDTH:0]  q;
    logic [CW-1:0]   cnt;
    logic            cin;
    logic            unused_cout;

    // Negative partial products are formed as ~pp + 1 via the adder carry-in.
    always_comb begin
        y   = '0;
        cin = 1'b0;
        unique case (q[2:0])
            3'b001, 3'b010: y = m;
            3'b011:         y = m << 1;
            3'b100: begin
                y   = ~(m << 1);
                cin = 1'b1;
            end
            3'b101, 3'b110: begin
                y   = ~m;
                cin = 1'b1;
            end
            default: ;
        endcase
    end

    adder_64b #(.N(DW)) u_add (
        .x    (acc),
        .y    (y),
        .cin  (cin),
        .sum  (sum),
        .cout (unused_cout)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {{WIDTH{mcand[WIDTH-1]}}, mcand};
                        q     <= {mplier, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    q   <= {{2{q[WIDTH]}}, q[WIDTH:2]};
                    m   <= m << 2;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) begin
                        {hi, lo} <= sum;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
